exc_redirect_ctrl: RTL and testbench



---
 rtl/exc_redirect_ctrl_pkg.sv | 24 ++
 rtl/exc_redirect_ctrl_if.sv | 24 ++
 rtl/exc_redirect_ctrl_inst_req_tracker.sv | 36 +++
 rtl/exc_redirect_ctrl.sv | 97 +++++++++
 tb/tb_exc_redirect_ctrl.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/exc_redirect_ctrl_pkg.sv
// Shared types and constants for the exception/ERET flush-and-redirect controller.
// State codes and the default exception vector live here so fetch-side blocks agree on them.
package exc_redirect_ctrl_pkg;

  localparam logic [31:0] EXC_VECTOR_DEF = 32'hbfc00380;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    CANCEL   = 2'b01,
    REDIRECT = 2'b10
  } state_e;

  typedef struct packed {
    logic        exc;
    logic        eret;
    logic [31:0] epc;
  } wb_req_t;

  // Exception wins over ERET when both commit together.
  function automatic logic [31:0] redirect_target(input wb_req_t req, input logic [31:0] vec);
    return req.exc ? vec : req.epc;
  endfunction

endpackage

// File: rtl/exc_redirect_ctrl_if.sv
// Bundle of WB-side requests, inst-SRAM handshake events and the fetch redirect outputs.
interface exc_redirect_ctrl_if;
  logic        ws_exc;
  logic        ws_eret;
  logic [31:0] cp0_epc;
  logic        inst_req_fire;
  logic        inst_data_ok;
  logic        redirect_ready;
  logic        flush;
  logic        drop_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ctrl_busy;

  modport master (
    output ws_exc, ws_eret, cp0_epc, inst_req_fire, inst_data_ok, redirect_ready,
    input  flush, drop_resp, redirect_valid, redirect_pc, ctrl_busy
  );

  modport slave (
    input  ws_exc, ws_eret, cp0_epc, inst_req_fire, inst_data_ok, redirect_ready,
    output flush, drop_resp, redirect_valid, redirect_pc, ctrl_busy
  );
endinterface

// File: rtl/exc_redirect_ctrl_inst_req_tracker.sv
// Up/down count of inst-SRAM requests accepted but not yet answered.
// cnt_d is exported so the controller can snapshot the post-cycle count.
module exc_redirect_ctrl_inst_req_tracker #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_fire,
  input  logic             data_ok,
  output logic [CNT_W-1:0] cnt_q,
  output logic [CNT_W-1:0] cnt_d
);

  always_comb begin
    cnt_d = cnt_q;
    case ({req_fire, data_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      assert (!(req_fire && !data_ok && cnt_q == CNT_W'(MAX_OUTSTANDING)))
        else $error("inst_req_tracker: outstanding overflow");
      assert (!(data_ok && !req_fire && cnt_q == '0))
        else $error("inst_req_tracker: outstanding underflow");
    end
  end

endmodule

// File: rtl/exc_redirect_ctrl.sv
// Flushes the pipeline on a WB exception/ERET, drains stale inst-SRAM responses,
// then holds the new fetch PC for pre-IF until it is accepted.
module exc_redirect_ctrl
  import exc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR      = EXC_VECTOR_DEF,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          CNT_W           = 2
) (
  input  logic                clk,
  input  logic                reset,
  exc_redirect_ctrl_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  discard_q, discard_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic              trig;
  logic              flush, drop_resp, redirect_valid, ctrl_busy;
  wb_req_t           wb_req;

  exc_redirect_ctrl_inst_req_tracker #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CNT_W          (CNT_W)
  ) u_tracker (
    .clk     (clk),
    .reset   (reset),
    .req_fire(bus.inst_req_fire),
    .data_ok (bus.inst_data_ok),
    .cnt_q   (out_cnt_q),
    .cnt_d   (out_cnt_d)
  );

  assign wb_req = '{exc: bus.ws_exc, eret: bus.ws_eret, epc: bus.cp0_epc};
  assign trig   = bus.ws_exc | bus.ws_eret;

  always_comb begin
    state_d        = state_q;
    discard_d      = discard_q;
    redirect_pc_d  = redirect_pc_q;
    flush          = 1'b0;
    drop_resp      = 1'b0;
    redirect_valid = 1'b0;
    ctrl_busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig) begin
          flush         = 1'b1;
          drop_resp     = bus.inst_data_ok;
          redirect_pc_d = redirect_target(wb_req, EXC_VECTOR);
          // A request accepted this very cycle targets the old PC, so it is stale too.
          discard_d     = out_cnt_d;
          state_d       = (out_cnt_d == '0) ? REDIRECT : CANCEL;
        end
      end
      CANCEL: begin
        ctrl_busy = 1'b1;
        drop_resp = bus.inst_data_ok;
        if (bus.inst_data_ok) begin
          discard_d = discard_q - CNT_W'(1);
          if (discard_q == CNT_W'(1)) state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        ctrl_busy      = 1'b1;
        redirect_valid = 1'b1;
        if (bus.redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      discard_q     <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      discard_q     <= discard_d;
      redirect_pc_q <= redirect_pc_d;
      assert (!(state_q == CANCEL && bus.inst_req_fire))
        else $error("exc_redirect_ctrl: inst request issued while cancelling");
      assert (!(trig && state_q != IDLE))
        else $warning("exc_redirect_ctrl: trig ignored outside IDLE");
    end
  end

  // Outputs are forced low while reset is held, whatever state is being left.
  assign bus.flush          = flush & ~reset;
  assign bus.drop_resp      = drop_resp & ~reset;
  assign bus.redirect_valid = redirect_valid & ~reset;
  assign bus.ctrl_busy      = ctrl_busy & ~reset;
  assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Directed bench for exc_redirect_ctrl: per-cycle output checks plus a redirect-PC scoreboard.
module tb_exc_redirect_ctrl;
  import exc_redirect_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   redir_cnt = 0;
  logic [31:0] exp_pc[$];

  exc_redirect_ctrl_if bus();

  exc_redirect_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge and settle before sampling.
  task automatic step(input logic rst, input logic e, input logic r, input logic [31:0] epc,
                      input logic f, input logic o, input logic rd);
    @(posedge clk); #1;
    reset = rst;
    bus.ws_exc = e; bus.ws_eret = r; bus.cp0_epc = epc;
    bus.inst_req_fire = f; bus.inst_data_ok = o; bus.redirect_ready = rd;
    #3;
  endtask

  task automatic chk_out(input string tag, input logic fl, input logic dr, input logic rv,
                         input logic busy);
    chk({tag, "_flush"}, bus.flush, fl);
    chk({tag, "_drop"}, bus.drop_resp, dr);
    chk({tag, "_rvalid"}, bus.redirect_valid, rv);
    chk({tag, "_busy"}, bus.ctrl_busy, busy);
  endtask

  // Scoreboard: every accepted redirect must match the oldest expected PC.
  always @(negedge clk) begin
    if (!reset && bus.redirect_valid && bus.redirect_ready) begin
      redir_cnt++;
      if (exp_pc.size() == 0) chk("sb_underrun", 32'(exp_pc.size()), 32'd1);
      else chk("sb_pc", bus.redirect_pc, exp_pc.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.ws_exc = 0; bus.ws_eret = 0; bus.cp0_epc = 0;
    bus.inst_req_fire = 0; bus.inst_data_ok = 0; bus.redirect_ready = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk_out("rst", 0, 0, 0, 0);
    chk("rst_pc", bus.redirect_pc, 32'h0);

    // 1: exception with nothing in flight
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0); exp_pc.push_back(32'hbfc00380);
    chk_out("t1_c0", 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_out("t1_c1", 0, 0, 1, 1);
    chk("t1_pc", bus.redirect_pc, 32'hbfc00380);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_out("t1_idle", 0, 0, 0, 0);

    // 2: ERET with two requests outstanding
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 32'h80001234, 0, 0, 0); exp_pc.push_back(32'h80001234);
    chk_out("t2_trig", 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_out("t2_wait", 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk_out("t2_drop0", 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk_out("t2_drop1", 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_out("t2_redir", 0, 0, 1, 1);
    chk("t2_pc", bus.redirect_pc, 32'h80001234);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_out("t2_idle", 0, 0, 0, 0);

    // 3: trig coincides with data_ok and req_fire, one outstanding -> discard stays 1
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 1, 1, 0); exp_pc.push_back(32'hbfc00380);
    chk_out("t3_trig", 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_out("t3_cancel", 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk_out("t3_drop", 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_out("t3_redir", 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_out("t3_idle", 0, 0, 0, 0);

    // 4: exc and eret together, ready withheld for five cycles
    step(0, 1, 1, 32'h12345678, 0, 0, 0); exp_pc.push_back(32'hbfc00380);
    chk_out("t4_trig", 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 32'h12345678, 0, 0, 0);
      chk_out("t4_hold", 0, 0, 1, 1);
      chk("t4_pc", bus.redirect_pc, 32'hbfc00380);
    end
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_out("t4_idle", 0, 0, 0, 0);

    // 5: reset while cancelling aborts the sequence
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    chk_out("t5_trig", 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_out("t5_cancel", 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_out("t5_post", 0, 0, 0, 0);
    chk("t5_pc", bus.redirect_pc, 32'h0);
    step(0, 1, 0, 0, 0, 0, 0); exp_pc.push_back(32'hbfc00380);
    chk_out("t5_t1c0", 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_out("t5_t1c1", 0, 0, 1, 1);
    chk("t5_t1pc", bus.redirect_pc, 32'hbfc00380);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_out("t5_idle", 0, 0, 0, 0);

    // 6: trig while redirecting is ignored
    step(0, 0, 1, 32'h11110000, 0, 0, 0); exp_pc.push_back(32'h11110000);
    chk_out("t6_trig", 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_out("t6_redir", 0, 0, 1, 1);
    step(0, 1, 0, 32'h22220000, 0, 0, 0);
    chk_out("t6_retrig", 0, 0, 1, 1);
    chk("t6_pc0", bus.redirect_pc, 32'h11110000);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("t6_pc1", bus.redirect_pc, 32'h11110000);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk_out("t6_idle", 0, 0, 0, 0);

    step(0, 0, 0, 0, 0, 0, 0);
    chk("sb_left", 32'(exp_pc.size()), 32'd0);
    chk("sb_count", 32'(redir_cnt), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
